// File: rtl/dct_feed_ctrl.sv
// Forward-DCT feed scheduler: turns one TU request at a time into a per-row
// valid/transize stream and flags when each TU's last row leaves the DCT pipe.
module dct_feed_ctrl #(
  parameter int PIPE_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [1:0] i_transize,
  input  logic       i_stall,
  output logic       o_ready,
  output logic       o_valid,
  output logic [1:0] o_transize,
  output logic [4:0] o_row_idx,
  output logic       o_first,
  output logic       o_last,
  output logic       o_done,
  output logic       o_busy
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state, state_d;
  logic [4:0]            cnt, cnt_d, cnt_max;
  logic [1:0]            size_q, size_d;
  logic [5:0]            rows;
  logic                  at_last;
  logic                  valid_d, first_d, last_d;
  logic [4:0]            row_idx_d;
  logic [1:0]            transize_d;
  logic [PIPE_DEPTH-1:0] done_sr;

  assign rows    = 6'd4 << size_q;
  assign cnt_max = 5'(rows - 6'd1);
  assign at_last = (cnt == cnt_max);

  // A new TU may be taken while the final row of the current one goes out.
  assign o_ready = (state == IDLE) || ((state == SEND) && at_last && !i_stall);
  assign o_done  = done_sr[PIPE_DEPTH-1];
  assign o_busy  = (state == SEND) || o_valid || (|done_sr);

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    size_d     = size_q;
    valid_d    = 1'b0;
    first_d    = 1'b0;
    last_d     = 1'b0;
    row_idx_d  = o_row_idx;
    transize_d = o_transize;
    case (state)
      IDLE: begin
        if (i_start) begin
          size_d  = i_transize;
          cnt_d   = 5'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (!i_stall) begin
          valid_d    = 1'b1;
          row_idx_d  = cnt;
          first_d    = (cnt == 5'd0);
          last_d     = at_last;
          transize_d = size_q;
          if (!at_last) begin
            cnt_d = cnt + 5'd1;
          end else if (i_start) begin
            size_d = i_transize;
            cnt_d  = 5'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 5'd0;
      size_q     <= 2'd0;
      o_valid    <= 1'b0;
      o_first    <= 1'b0;
      o_last     <= 1'b0;
      o_row_idx  <= 5'd0;
      o_transize <= 2'd0;
      done_sr    <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      size_q     <= size_d;
      o_valid    <= valid_d;
      o_first    <= first_d;
      o_last     <= last_d;
      o_row_idx  <= row_idx_d;
      o_transize <= transize_d;
      // Each issued last row rides this line until it exits the DCT pipe.
      done_sr    <= (done_sr << 1) | PIPE_DEPTH'(o_valid & o_last);
    end
  end

endmodule

// File: tb/tb_dct_feed_ctrl.sv
// Bench for dct_feed_ctrl: directed scenarios then random traffic, checked
// against a row-queue reference model with immediate assertions.
module tb_dct_feed_ctrl;

  localparam int PIPE_DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_start;
  logic [1:0] i_transize;
  logic       i_stall;
  logic       o_ready, o_valid, o_first, o_last, o_done, o_busy;
  logic [1:0] o_transize;
  logic [4:0] o_row_idx;

  dct_feed_ctrl #(.PIPE_DEPTH(PIPE_DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_transize (i_transize),
    .i_stall    (i_stall),
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .o_transize (o_transize),
    .o_row_idx  (o_row_idx),
    .o_first    (o_first),
    .o_last     (o_last),
    .o_done     (o_done),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       row;
    bit       last;
    bit [1:0] size;
  } row_t;

  // Model: rows still owed to the DCT, plus cycle stamps of expected done pulses.
  row_t q[$];
  int   dues[$];
  int   cyc;
  bit       e_valid, e_first, e_last;
  int       e_row;
  bit [1:0] e_tsize;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    dues.delete();
    e_valid = 0; e_first = 0; e_last = 0; e_row = 0; e_tsize = 0;
  endtask

  task automatic model_edge(input bit acc, input bit [1:0] sz, input bit st);
    row_t r;
    int   n;
    cyc++;
    while (dues.size() > 0 && dues[0] < cyc) void'(dues.pop_front());
    if (q.size() > 0 && !st) begin
      r = q.pop_front();
      e_valid = 1; e_row = r.row; e_first = (r.row == 0); e_last = r.last; e_tsize = r.size;
      if (r.last) dues.push_back(cyc + PIPE_DEPTH);
    end else begin
      e_valid = 0; e_first = 0; e_last = 0;
    end
    if (acc) begin
      n = 4 << sz;
      for (int k = 0; k < n; k++) q.push_back('{row: k, last: (k == n - 1), size: sz});
    end
  endtask

  task automatic check_output();
    bit exp_done;
    bit exp_busy;
    exp_done = (dues.size() > 0) && (dues[0] == cyc);
    exp_busy = (q.size() > 0) || e_valid || (dues.size() > 0);
    chk("valid",    32'(o_valid),    32'(e_valid));
    chk("row_idx",  32'(o_row_idx),  32'(e_row));
    chk("transize", 32'(o_transize), 32'(e_tsize));
    chk("first",    32'(o_first),    32'(e_first));
    chk("last",     32'(o_last),     32'(e_last));
    chk("done",     32'(o_done),     32'(exp_done));
    chk("busy",     32'(o_busy),     32'(exp_busy));
  endtask

  task automatic apply_stimulus(input bit s, input bit [1:0] sz, input bit st);
    bit rdy;
    i_start = s; i_transize = sz; i_stall = st;
    #1;
    rdy = (q.size() == 0) || (q.size() == 1 && !st);
    chk("ready", 32'(o_ready), 32'(rdy));
    @(posedge clk);
    model_edge(s && rdy, sz, st);
    #1;
    check_output();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(0, 2'($urandom_range(0, 3)), 0);
  endtask

  initial begin
    rst = 1'b0; i_start = 0; i_transize = 0; i_stall = 0;
    cyc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_output();
    @(negedge clk) rst = 1'b1;

    // 4x4 TU: rows 0..3, done four edges after the last row.
    apply_stimulus(1, 0, 0);
    idle(10);

    // 32x32 TU with a three-cycle stall after row 10.
    apply_stimulus(1, 3, 0);
    for (int i = 1; i < 40; i++) apply_stimulus(0, 0, (i >= 12 && i < 15));
    idle(6);

    // 8x8 then 16x16 back to back.
    apply_stimulus(1, 1, 0);
    for (int i = 1; i < 8; i++) apply_stimulus(0, 0, 0);
    apply_stimulus(1, 2, 0);
    idle(24);

    // Request mid-TU is dropped while i_transize wiggles.
    apply_stimulus(1, 1, 0);
    for (int i = 1; i < 12; i++) apply_stimulus((i == 4), 2'(i), 0);
    idle(6);

    // Stall on the last row with a request held.
    apply_stimulus(1, 0, 0);
    for (int i = 1; i < 4; i++) apply_stimulus(0, 0, 0);
    apply_stimulus(1, 1, 1);
    apply_stimulus(1, 1, 1);
    apply_stimulus(1, 1, 0);
    idle(16);

    // Asynchronous reset in the middle of a 16x16 TU.
    apply_stimulus(1, 2, 0);
    for (int i = 1; i < 7; i++) apply_stimulus(0, 0, 0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_output();
    @(negedge clk) rst = 1'b1;
    apply_stimulus(1, 0, 0);
    idle(12);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      apply_stimulus(($urandom % 4) == 0, 2'($urandom_range(0, 3)), ($urandom % 5) == 0);
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
